// File: rtl/fp_calc_pkg.sv
// Shared types and FP32 constants for the MiniS08 FP calculator operand path.
package fp_calc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCUM,
      ST_START,
      ST_WAIT,
      ST_OUT
   } acc_state_t;

   localparam int unsigned SIGN_BIT = 31;
   localparam int unsigned EXP_MSB  = 30;
   localparam int unsigned EXP_LSB  = 23;
   localparam int unsigned MAN_MSB  = 22;
   localparam int unsigned MAN_LSB  = 0;

   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [31:0] FP_ZERO = 32'h0000_0000;

   function automatic logic [31:0] fp_neg(input logic [31:0] x);
      logic [31:0] r;
      r           = x;
      r[SIGN_BIT] = ~x[SIGN_BIT];
      return r;
   endfunction

endpackage

// File: rtl/fp_acc_watchdog.sv
// Add/sub completion watchdog: cleared by load, counts while run, flags expiry
// on the TIMEOUT_CYCLES-th run cycle. Only built with FP_ACC_WATCHDOG_EN.
module fp_acc_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt;
   logic          at_limit;

   assign at_limit = (cnt == CW'(TIMEOUT_CYCLES - 1));
   assign expire   = run & at_limit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (run && !at_limit) begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fp_accum_seq.sv
// FP32 packet accumulator driving the add/sub Start/sumdone handshake.
// Define FP_ACC_WATCHDOG_EN to build the add_done timeout watchdog and err flag.
module fp_accum_seq
   import fp_calc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             add_start,
   output logic [31:0]      add_x,
   output logic [31:0]      add_y,
   input  logic             add_done,
   input  logic [31:0]      add_result,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [31:0]      acc_result,
   output logic [CNT_W-1:0] acc_count,
   output logic             err
);

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("fp_accum_seq: TIMEOUT_CYCLES must be nonzero");
   end

   acc_state_t       state, state_nxt;
   logic [31:0]      acc, y_q;
   logic             last_q;
   logic [CNT_W-1:0] count;
   logic [31:0]      beat_val;
   logic             wd_expire;

   assign beat_val   = in_sub ? fp_neg(in_data) : in_data;
   assign acc_result = acc;
   assign acc_count  = count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // add_done outside WAIT falls through every arm untouched, so late pulses are ignored.
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      add_start = 1'b0;
      add_x     = '0;
      add_y     = '0;
      acc_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = in_last ? ST_OUT : ST_ACCUM;
         end
         ST_ACCUM: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = ST_START;
         end
         ST_START: begin
            add_start = 1'b1;
            add_x     = acc;
            add_y     = y_q;
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (add_done)       state_nxt = last_q ? ST_OUT : ST_ACCUM;
            else if (wd_expire) state_nxt = ST_OUT;
         end
         ST_OUT: begin
            acc_valid = 1'b1;
            if (acc_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= FP_ZERO;
         y_q    <= FP_ZERO;
         last_q <= 1'b0;
         count  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  acc   <= beat_val;
                  count <= CNT_W'(1);
               end
            end
            ST_ACCUM: begin
               if (in_valid) begin
                  y_q    <= beat_val;
                  last_q <= in_last;
                  if (count != '1) count <= count + CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (add_done)       acc <= add_result;
               else if (wd_expire) acc <= FP_QNAN;
            end
            default: ;
         endcase
      end
   end

`ifdef FP_ACC_WATCHDOG_EN
   logic err_q;

   fp_acc_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (state == ST_START),
      .run    (state == ST_WAIT),
      .expire (wd_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         err_q <= 1'b0;
      else if (state == ST_WAIT && !add_done && wd_expire) err_q <= 1'b1;
   end

   assign err = err_q;
`else
   assign wd_expire = 1'b0;
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq with a behavioural add/sub unit of programmable latency.
// Watchdog case is compiled in when FP_ACC_WATCHDOG_EN is defined.
module tb_fp_accum_seq;

   localparam int unsigned TO    = 64;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready, in_sub, in_last;
   logic [31:0]      in_data;
   logic             add_start;
   logic [31:0]      add_x, add_y;
   logic             add_done = 1'b0;
   logic [31:0]      add_result = '0;
   logic             acc_valid, acc_ready;
   logic [31:0]      acc_result;
   logic [CNT_W-1:0] acc_count;
   logic             err;

   int total = 0;
   int bad   = 0;

   int          lat_cfg  = 1;
   logic        done_en  = 1'b1;
   int          n_starts = 0;
   logic [31:0] last_x   = '0;
   logic [31:0] last_y   = '0;
   int          busy_cnt = 0;
   logic        busy     = 1'b0;
   logic [31:0] res_q    = '0;

   fp_accum_seq #(
      .TIMEOUT_CYCLES(TO),
      .CNT_W         (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_sub     (in_sub),
      .in_last    (in_last),
      .add_start  (add_start),
      .add_x      (add_x),
      .add_y      (add_y),
      .add_done   (add_done),
      .add_result (add_result),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .acc_result (acc_result),
      .acc_count  (acc_count),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Normal numbers and zero only; enough for the exact values used here.
   function automatic real s2r(input logic [31:0] a);
      logic [10:0] e;
      if (a[30:23] == 8'd0) return 0.0;
      e = {3'b000, a[30:23]} + 11'd896;
      return $bitstoreal({a[31], e, a[22:0], 29'b0});
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0000_0000;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      return r2s(s2r(a) + s2r(b));
   endfunction

   // Behavioural add/sub unit; keeps running across DUT reset so late dones can occur.
   always @(posedge clk) begin
      add_done   <= 1'b0;
      add_result <= '0;
      if (add_start) begin
         n_starts <= n_starts + 1;
         last_x   <= add_x;
         last_y   <= add_y;
         if (lat_cfg <= 1) begin
            add_done   <= done_en;
            add_result <= done_en ? fadd(add_x, add_y) : 32'h0;
         end else begin
            busy     <= 1'b1;
            busy_cnt <= lat_cfg - 1;
            res_q    <= fadd(add_x, add_y);
         end
      end else if (busy) begin
         if (busy_cnt <= 1) begin
            busy       <= 1'b0;
            add_done   <= done_en;
            add_result <= done_en ? res_q : 32'h0;
         end else begin
            busy_cnt <= busy_cnt - 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beat(input logic [31:0] d, input logic sub, input logic last);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_sub   = sub;
      in_last  = last;
      n = 0;
      while (!in_ready && n < 200) begin
         cyc(1);
         n++;
      end
      if (n >= 200) check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      cyc(1);
      in_valid = 1'b0;
      in_sub   = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid(input int max);
      int n;
      n = 0;
      while (!acc_valid && n < max) begin
         cyc(1);
         n++;
      end
      if (n >= max) check("acc_valid_timeout", {31'b0, acc_valid}, 32'd1);
   endtask

   task automatic take_result();
      acc_ready = 1'b1;
      cyc(1);
      acc_ready = 1'b0;
      check("valid_drop", {31'b0, acc_valid}, 32'd0);
      check("ready_back", {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int s0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_sub    = 1'b0;
      in_last   = 1'b0;
      acc_ready = 1'b0;
      cyc(3);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(1);

      check("rst_in_ready",   {31'b0, in_ready},  32'd1);
      check("rst_add_start",  {31'b0, add_start}, 32'd0);
      check("rst_add_x",      add_x,              32'h0);
      check("rst_add_y",      add_y,              32'h0);
      check("rst_acc_valid",  {31'b0, acc_valid}, 32'd0);
      check("rst_acc_result", acc_result,         32'h0);
      check("rst_acc_count",  32'(acc_count),     32'd0);
      check("rst_err",        {31'b0, err},       32'd0);

      // 1.0 + 2.0 = 3.0
      lat_cfg = 3;
      s0 = n_starts;
      send_beat(32'h3F80_0000, 1'b0, 1'b0);
      send_beat(32'h4000_0000, 1'b0, 1'b1);
      wait_valid(50);
      check("p1_starts", 32'(n_starts - s0), 32'd1);
      check("p1_x",      last_x,             32'h3F80_0000);
      check("p1_y",      last_y,             32'h4000_0000);
      check("p1_result", acc_result,         32'h4040_0000);
      check("p1_count",  32'(acc_count),     32'd2);
      check("p1_ready",  {31'b0, in_ready},  32'd0);
      take_result();
      check("p1_count_hold", 32'(acc_count), 32'd2);

      // 3.0 - 3.0 with done one cycle after start
      lat_cfg = 1;
      s0 = n_starts;
      send_beat(32'h4040_0000, 1'b0, 1'b0);
      send_beat(32'h4040_0000, 1'b1, 1'b1);
      wait_valid(50);
      check("p2_starts", 32'(n_starts - s0), 32'd1);
      check("p2_y",      last_y,             32'hC040_0000);
      check("p2_result", acc_result,         32'h0000_0000);
      check("p2_count",  32'(acc_count),     32'd2);
      take_result();

      // single beat, then consumer stalls 10 cycles
      s0 = n_starts;
      send_beat(32'hC120_0000, 1'b0, 1'b1);
      check("p3_valid",  {31'b0, acc_valid}, 32'd1);
      check("p3_result", acc_result,         32'hC120_0000);
      check("p3_count",  32'(acc_count),     32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("stall_valid",  {31'b0, acc_valid}, 32'd1);
         check("stall_result", acc_result,         32'hC120_0000);
         check("stall_ready",  {31'b0, in_ready},  32'd0);
      end
      check("p3_starts", 32'(n_starts - s0), 32'd0);
      take_result();

      // 1.0 + 2.0 + 4.0 = 7.0
      lat_cfg = 5;
      s0 = n_starts;
      send_beat(32'h3F80_0000, 1'b0, 1'b0);
      send_beat(32'h4000_0000, 1'b0, 1'b0);
      send_beat(32'h4080_0000, 1'b0, 1'b1);
      wait_valid(80);
      check("p4_starts", 32'(n_starts - s0), 32'd2);
      check("p4_x",      last_x,             32'h4040_0000);
      check("p4_result", acc_result,         32'h40E0_0000);
      check("p4_count",  32'(acc_count),     32'd3);
      take_result();

      // asynchronous reset while waiting on the add/sub unit, late done afterwards
      lat_cfg = 8;
      s0 = n_starts;
      send_beat(32'h3F80_0000, 1'b0, 1'b0);
      send_beat(32'h4000_0000, 1'b0, 1'b1);
      cyc(2);
      check("wait_starts", 32'(n_starts - s0), 32'd1);
      check("wait_ready",  {31'b0, in_ready},  32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready",   {31'b0, in_ready},  32'd1);
      check("arst_acc_valid",  {31'b0, acc_valid}, 32'd0);
      check("arst_acc_result", acc_result,         32'h0);
      check("arst_acc_count",  32'(acc_count),     32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      cyc(12);
      check("late_busy",       {31'b0, busy},      32'd0);
      check("late_in_ready",   {31'b0, in_ready},  32'd1);
      check("late_add_start",  {31'b0, add_start}, 32'd0);
      check("late_acc_valid",  {31'b0, acc_valid}, 32'd0);
      check("late_acc_result", acc_result,         32'h0);
      check("late_acc_count",  32'(acc_count),     32'd0);
      check("late_err",        {31'b0, err},       32'd0);
      send_beat(32'h3F80_0000, 1'b0, 1'b1);
      check("post_rst_result", acc_result, 32'h3F80_0000);
      check("post_rst_count",  32'(acc_count), 32'd1);
      take_result();

`ifdef FP_ACC_WATCHDOG_EN
      done_en = 1'b0;
      lat_cfg = 2;
      send_beat(32'h3F80_0000, 1'b0, 1'b0);
      send_beat(32'h4000_0000, 1'b0, 1'b1);
      cyc(TO - 4);
      check("wd_err_early", {31'b0, err}, 32'd0);
      wait_valid(40);
      check("wd_err",    {31'b0, err}, 32'd1);
      check("wd_result", acc_result,   32'h7FC0_0000);
      take_result();
      check("wd_err_sticky", {31'b0, err}, 32'd1);
      done_en = 1'b1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
